// File: rtl/dqs_eye_centering_ctrl.sv
// ============================================================================
// dqs_eye_centering_ctrl
// Per-lane DQS read-eye training controller. It sweeps the IOD delay line
// upwards from tap 0 and records the first contiguous passing window. If that
// window is wide enough, it steps the delay line back down to the window
// centre.
//
// Optional feature: when DQS_TRAIN_DIAG_EN is defined, the FAIL_CODE and
// LAST_SWEEP_TAP outputs are added.
//
// Ports:
//   FAB_CLK, SYNC_RST         : clock and synchronous active-high reset
//   TRAIN_START               : level request; only sampled while idle
//   TRAIN_BUSY                : high in every state except IDLE
//   TRAIN_DONE/TRAIN_FAIL     : sticky result flags
//   CENTER_TAP, WINDOW_WIDTH  : training result
//   EYE_MONITOR_EARLY/LATE    : eye-monitor flags from the IOD
//   DELAY_LINE_OUT_OF_RANGE   : delay-line limit flag from the IOD
//   EYE_MONITOR_CLEAR_FLAGS   : one-cycle flag-clear pulse to the IOD
//   DELAY_LINE_MOVE/DIRECTION : one tap step per MOVE pulse; DIRECTION=1 steps up
//   DELAY_LINE_LOAD           : one-cycle reload of the delay line to tap 0
//   FAIL_CODE, LAST_SWEEP_TAP : diagnostics (DQS_TRAIN_DIAG_EN only)
// ============================================================================
module dqs_eye_centering_ctrl #(
    parameter int unsigned TAP_W         = 8,
    parameter int unsigned MAX_TAPS      = 255,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned SAMPLE_CYCLES = 16,
    parameter int unsigned MIN_WINDOW    = 4
) (
    input  logic             FAB_CLK,
    input  logic             SYNC_RST,
    input  logic             TRAIN_START,
    output logic             TRAIN_BUSY,
    output logic             TRAIN_DONE,
    output logic             TRAIN_FAIL,
    output logic [TAP_W-1:0] CENTER_TAP,
    output logic [TAP_W-1:0] WINDOW_WIDTH,
    input  logic             EYE_MONITOR_EARLY,
    input  logic             EYE_MONITOR_LATE,
    input  logic             DELAY_LINE_OUT_OF_RANGE,
    output logic             EYE_MONITOR_CLEAR_FLAGS,
    output logic             DELAY_LINE_MOVE,
    output logic             DELAY_LINE_DIRECTION,
    output logic             DELAY_LINE_LOAD
`ifdef DQS_TRAIN_DIAG_EN
    ,
    output logic [1:0]       FAIL_CODE,
    output logic [TAP_W-1:0] LAST_SWEEP_TAP
`endif
);

    localparam int unsigned WW    = TAP_W + 1;
    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + SAMPLE_CYCLES) + 1;

    typedef enum logic [2:0] {
        IDLE, LOAD, CLEAR, SETTLE, SAMPLE, EVAL, STEP, RETURN
    } state_t;

    state_t             state_q;
    logic [TAP_W-1:0]   tap_q, first_q, last_q, back_q, center_q, width_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               in_win_q, err_q, phase_q;
    logic               busy_q, done_q, fail_q, clr_q, move_q, dir_q, load_q;

    // Evaluation of the tap just sampled
    logic               pass_c, in_win_c, sweep_end_c, win_ok_c;
    logic [TAP_W-1:0]   first_c, last_c, center_c, width_sat_c;
    logic [WW-1:0]      width_c, sum_c;

    always_comb begin
        pass_c   = !err_q && !DELAY_LINE_OUT_OF_RANGE;
        first_c  = first_q;
        last_c   = last_q;
        in_win_c = in_win_q;
        if (pass_c) begin
            if (!in_win_q) begin
                first_c  = tap_q;
                in_win_c = 1'b1;
            end
            last_c = tap_q;
        end
        sweep_end_c = (!pass_c && in_win_q) || DELAY_LINE_OUT_OF_RANGE ||
                      (tap_q == TAP_W'(MAX_TAPS));
        width_c     = in_win_c ? (WW'(last_c) - WW'(first_c) + WW'(1)) : '0;
        win_ok_c    = in_win_c && (width_c >= WW'(MIN_WINDOW));
        // A window spanning the full tap range would overflow; saturate it.
        width_sat_c = width_c[TAP_W] ? '1 : width_c[TAP_W-1:0];
        sum_c       = WW'(first_c) + WW'(last_c);
        center_c    = TAP_W'(sum_c >> 1);
    end

    // Training sequencer
    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            state_q  <= IDLE;
            tap_q    <= '0;
            first_q  <= '0;
            last_q   <= '0;
            back_q   <= '0;
            center_q <= '0;
            width_q  <= '0;
            cnt_q    <= '0;
            in_win_q <= 1'b0;
            err_q    <= 1'b0;
            phase_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fail_q   <= 1'b0;
            clr_q    <= 1'b0;
            move_q   <= 1'b0;
            dir_q    <= 1'b0;
            load_q   <= 1'b0;
`ifdef DQS_TRAIN_DIAG_EN
            FAIL_CODE      <= 2'd0;
            LAST_SWEEP_TAP <= '0;
`endif
        end else begin
            // All IOD controls are single-cycle pulses.
            clr_q  <= 1'b0;
            move_q <= 1'b0;
            dir_q  <= 1'b0;
            load_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (TRAIN_START) begin
                        done_q   <= 1'b0;
                        fail_q   <= 1'b0;
                        center_q <= '0;
                        width_q  <= '0;
                        busy_q   <= 1'b1;
                        load_q   <= 1'b1;
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    tap_q    <= '0;
                    in_win_q <= 1'b0;
                    clr_q    <= 1'b1;
                    state_q  <= CLEAR;
                end
                CLEAR: begin
                    err_q   <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= SETTLE;
                end
                SETTLE: begin
                    if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        state_q <= SAMPLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                SAMPLE: begin
                    err_q <= err_q | EYE_MONITOR_EARLY | EYE_MONITOR_LATE;
                    if (cnt_q == CNT_W'(SAMPLE_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        state_q <= EVAL;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                EVAL: begin
                    first_q  <= first_c;
                    last_q   <= last_c;
                    in_win_q <= in_win_c;
                    if (sweep_end_c) begin
                        width_q <= width_sat_c;
`ifdef DQS_TRAIN_DIAG_EN
                        LAST_SWEEP_TAP <= tap_q;
                        if (win_ok_c)
                            FAIL_CODE <= 2'd0;
                        else if (in_win_c)
                            FAIL_CODE <= 2'd2;
                        else if (DELAY_LINE_OUT_OF_RANGE)
                            FAIL_CODE <= 2'd3;
                        else
                            FAIL_CODE <= 2'd1;
`endif
                        if (!win_ok_c) begin
                            fail_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            center_q <= center_c;
                            back_q   <= tap_q - center_c;
                            phase_q  <= 1'b0;
                            state_q  <= RETURN;
                        end
                    end else begin
                        move_q  <= 1'b1;
                        dir_q   <= 1'b1;
                        state_q <= STEP;
                    end
                end
                STEP: begin
                    tap_q   <= tap_q + TAP_W'(1);
                    clr_q   <= 1'b1;
                    state_q <= CLEAR;
                end
                RETURN: begin
                    // One down-step every other cycle until back reaches 0.
                    if (back_q == '0) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (!phase_q) begin
                        move_q  <= 1'b1;
                        back_q  <= back_q - TAP_W'(1);
                        phase_q <= 1'b1;
                    end else begin
                        phase_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign TRAIN_BUSY              = busy_q;
    assign TRAIN_DONE              = done_q;
    assign TRAIN_FAIL              = fail_q;
    assign CENTER_TAP              = center_q;
    assign WINDOW_WIDTH            = width_q;
    assign EYE_MONITOR_CLEAR_FLAGS = clr_q;
    assign DELAY_LINE_MOVE         = move_q;
    assign DELAY_LINE_DIRECTION    = dir_q;
    assign DELAY_LINE_LOAD         = load_q;

endmodule

// File: tb/tb_dqs_eye_centering_ctrl.sv
// ============================================================================
// tb_dqs_eye_centering_ctrl
// Directed bench for dqs_eye_centering_ctrl. A behavioural IOD model tracks
// the delay-line tap and counts up-moves, down-moves and loads. It answers
// EARLY, LATE and OUT_OF_RANGE from a per-test pass window.
// ============================================================================
module tb_dqs_eye_centering_ctrl;

    logic       FAB_CLK = 1'b0;
    logic       SYNC_RST;
    logic       TRAIN_START;
    logic       TRAIN_BUSY, TRAIN_DONE, TRAIN_FAIL;
    logic [7:0] CENTER_TAP, WINDOW_WIDTH;
    logic       EYE_MONITOR_EARLY, EYE_MONITOR_LATE, DELAY_LINE_OUT_OF_RANGE;
    logic       EYE_MONITOR_CLEAR_FLAGS, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD;
`ifdef DQS_TRAIN_DIAG_EN
    logic [1:0] FAIL_CODE;
    logic [7:0] LAST_SWEEP_TAP;
`endif

    int vectors   = 0;
    int miscompares = 0;

    // IOD model state and per-test pass window
    int tap_m   = 0;
    int ups_m   = 0;
    int downs_m = 0;
    int loads_m = 0;
    int pass_lo = 0;
    int pass_hi = -1;
    int oor_at  = -1;
    bit use_late = 1'b0;

    always #5 FAB_CLK = ~FAB_CLK;

    dqs_eye_centering_ctrl dut (
        .FAB_CLK                 (FAB_CLK),
        .SYNC_RST                (SYNC_RST),
        .TRAIN_START             (TRAIN_START),
        .TRAIN_BUSY              (TRAIN_BUSY),
        .TRAIN_DONE              (TRAIN_DONE),
        .TRAIN_FAIL              (TRAIN_FAIL),
        .CENTER_TAP              (CENTER_TAP),
        .WINDOW_WIDTH            (WINDOW_WIDTH),
        .EYE_MONITOR_EARLY       (EYE_MONITOR_EARLY),
        .EYE_MONITOR_LATE        (EYE_MONITOR_LATE),
        .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE),
        .EYE_MONITOR_CLEAR_FLAGS (EYE_MONITOR_CLEAR_FLAGS),
        .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
        .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
        .DELAY_LINE_LOAD         (DELAY_LINE_LOAD)
`ifdef DQS_TRAIN_DIAG_EN
        ,
        .FAIL_CODE               (FAIL_CODE),
        .LAST_SWEEP_TAP          (LAST_SWEEP_TAP)
`endif
    );

    logic in_pass;
    assign in_pass                 = (tap_m >= pass_lo) && (tap_m <= pass_hi);
    assign EYE_MONITOR_EARLY       = !in_pass && !use_late;
    assign EYE_MONITOR_LATE        = !in_pass && use_late;
    assign DELAY_LINE_OUT_OF_RANGE = (oor_at >= 0) && (tap_m >= oor_at);

    // Delay line model
    always @(posedge FAB_CLK) begin
        if (DELAY_LINE_LOAD) begin
            tap_m   <= 0;
            loads_m <= loads_m + 1;
        end else if (DELAY_LINE_MOVE) begin
            if (DELAY_LINE_DIRECTION) begin
                tap_m <= tap_m + 1;
                ups_m <= ups_m + 1;
            end else begin
                tap_m   <= tap_m - 1;
                downs_m <= downs_m + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    int ups0, downs0, loads0;

    // Pulse START (held three cycles; only the first is accepted) and wait for a result.
    task automatic run_train(input string tag);
        int n;
        ups0 = ups_m; downs0 = downs_m; loads0 = loads_m;
        @(negedge FAB_CLK) TRAIN_START = 1'b1;
        repeat (3) @(negedge FAB_CLK);
        TRAIN_START = 1'b0;
        n = 0;
        while (!(TRAIN_DONE || TRAIN_FAIL) && n < 9000) begin
            @(negedge FAB_CLK);
            n++;
        end
        check_eq({tag, "_finished"}, int'(n < 9000), 1);
        check_eq({tag, "_loads"}, loads_m - loads0, 1);
        check_eq({tag, "_busy"}, int'(TRAIN_BUSY), 0);
    endtask

    task automatic expect_result(input string tag, input int done, input int ups,
                                 input int downs, input int center, input int width,
                                 input int final_tap, input int code, input int last_tap);
        check_eq({tag, "_done"}, int'(TRAIN_DONE), done);
        check_eq({tag, "_fail"}, int'(TRAIN_FAIL), 1 - done);
        check_eq({tag, "_ups"}, ups_m - ups0, ups);
        check_eq({tag, "_downs"}, downs_m - downs0, downs);
        check_eq({tag, "_center"}, int'(CENTER_TAP), center);
        check_eq({tag, "_width"}, int'(WINDOW_WIDTH), width);
        check_eq({tag, "_tap"}, tap_m, final_tap);
`ifdef DQS_TRAIN_DIAG_EN
        check_eq({tag, "_code"}, int'(FAIL_CODE), code);
        check_eq({tag, "_lasttap"}, int'(LAST_SWEEP_TAP), last_tap);
`else
        if (code < 0 || last_tap < 0) check_eq({tag, "_args"}, 0, 1);
`endif
    endtask

    task automatic expect_all_zero(input string tag);
        check_eq({tag, "_busy"}, int'(TRAIN_BUSY), 0);
        check_eq({tag, "_done"}, int'(TRAIN_DONE), 0);
        check_eq({tag, "_fail"}, int'(TRAIN_FAIL), 0);
        check_eq({tag, "_center"}, int'(CENTER_TAP), 0);
        check_eq({tag, "_width"}, int'(WINDOW_WIDTH), 0);
        check_eq({tag, "_pulses"}, int'({EYE_MONITOR_CLEAR_FLAGS, DELAY_LINE_MOVE,
                                         DELAY_LINE_DIRECTION, DELAY_LINE_LOAD}), 0);
`ifdef DQS_TRAIN_DIAG_EN
        check_eq({tag, "_code"}, int'(FAIL_CODE), 0);
        check_eq({tag, "_lasttap"}, int'(LAST_SWEEP_TAP), 0);
`endif
    endtask

    initial begin
        int n;
        SYNC_RST    = 1'b1;
        TRAIN_START = 1'b0;
        repeat (3) @(negedge FAB_CLK);
        expect_all_zero("reset");
        SYNC_RST = 1'b0;
        repeat (2) @(negedge FAB_CLK);

        // Window 10..30, EARLY outside
        pass_lo = 10; pass_hi = 30; oor_at = -1; use_late = 1'b0;
        run_train("win10_30");
        expect_result("win10_30", 1, 31, 11, 20, 21, 20, 0, 31);

        // No window anywhere
        pass_lo = 0; pass_hi = -1; oor_at = -1; use_late = 1'b0;
        run_train("nowin");
        expect_result("nowin", 0, 255, 0, 0, 0, 255, 1, 255);

        // Narrow window 5..6, LATE outside
        pass_lo = 5; pass_hi = 6; oor_at = -1; use_late = 1'b1;
        run_train("narrow");
        expect_result("narrow", 0, 7, 0, 0, 2, 7, 2, 7);

        // Pass from 25, out of range at 40
        pass_lo = 25; pass_hi = 255; oor_at = 40; use_late = 1'b0;
        run_train("oor40");
        expect_result("oor40", 1, 40, 8, 32, 15, 32, 0, 40);

        // Window 200..255 ends at MAX_TAPS
        pass_lo = 200; pass_hi = 255; oor_at = -1; use_late = 1'b1;
        run_train("maxtap");
        expect_result("maxtap", 1, 255, 28, 227, 56, 227, 0, 255);

        // Mid-sweep reset during SAMPLE at tap 12, with START re-asserted while busy
        pass_lo = 10; pass_hi = 30; oor_at = -1; use_late = 1'b0;
        loads0 = loads_m;
        @(negedge FAB_CLK) TRAIN_START = 1'b1;
        @(negedge FAB_CLK) TRAIN_START = 1'b0;
        n = 0;
        while (tap_m != 12 && n < 2000) begin
            @(negedge FAB_CLK);
            n++;
        end
        check_eq("rst_reach_tap12", int'(n < 2000), 1);
        repeat (12) @(negedge FAB_CLK);
        TRAIN_START = 1'b1;
        repeat (2) @(negedge FAB_CLK);
        TRAIN_START = 1'b0;
        check_eq("rst_start_ignored", loads_m - loads0, 1);
        check_eq("rst_busy_before", int'(TRAIN_BUSY), 1);
        SYNC_RST = 1'b1;
        @(negedge FAB_CLK);
        expect_all_zero("midrst");
        SYNC_RST = 1'b0;
        ups0 = ups_m; downs0 = downs_m;
        repeat (300) @(negedge FAB_CLK);
        check_eq("rst_no_moves", (ups_m - ups0) + (downs_m - downs0), 0);
        check_eq("rst_idle", int'(TRAIN_BUSY), 0);

        // Restart after reset: from tap 0 with a fresh LOAD
        run_train("restart");
        expect_result("restart", 1, 31, 11, 20, 21, 20, 0, 31);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dqs_eye_centering_ctrl.md
Name: dqs_eye_centering_ctrl

Overview:
- Per-lane DQS read-eye training controller for the DDR4 PHY.
- Drives the DQS IOD's dynamic delay-line controls (LOAD/MOVE/DIRECTION) and eye-monitor clear.
- Consumes EYE_MONITOR_EARLY/LATE and DELAY_LINE_OUT_OF_RANGE from the IOD.
- Sweeps the delay line up from tap 0, records the first contiguous passing window, then steps back down to the window centre and reports the result.

Parameters:
TAP_W, 8, width of tap counters and result outputs
MAX_TAPS, 255, last tap visited by the sweep
SETTLE_CYCLES, 8, wait cycles after flag clear before sampling
SAMPLE_CYCLES, 16, cycles of early/late accumulation per tap
MIN_WINDOW, 4, minimum passing-window width (taps) for success

Ports:
FAB_CLK  in  1  fabric clock; sole clock, all logic on rising edge
SYNC_RST  in  1  synchronous active-high reset
TRAIN_START  in  1  level; sampled only in IDLE
TRAIN_BUSY  out  1  high in every state except IDLE
TRAIN_DONE  out  1  sticky success flag
TRAIN_FAIL  out  1  sticky failure flag
CENTER_TAP  out  TAP_W  final centre tap
WINDOW_WIDTH  out  TAP_W  last-first+1 of recorded window (0 if none)
EYE_MONITOR_EARLY  in  1  from IOD
EYE_MONITOR_LATE  in  1  from IOD
DELAY_LINE_OUT_OF_RANGE  in  1  from IOD
EYE_MONITOR_CLEAR_FLAGS  out  1  one-cycle pulse to IOD
DELAY_LINE_MOVE  out  1  one-cycle pulse per tap step
DELAY_LINE_DIRECTION  out  1  1=increment, 0=decrement; valid in any cycle MOVE=1
DELAY_LINE_LOAD  out  1  one-cycle pulse; reloads delay line to tap 0

Behaviour:
- Clock is FAB_CLK; reset is synchronous and active-high (SYNC_RST).
- Reset, including mid-operation: state IDLE, all outputs 0 on the next edge; no further pulses; counters cleared.
- IDLE: TRAIN_START=1 clears DONE/FAIL/CENTER_TAP/WINDOW_WIDTH, goes to LOAD. START is ignored in all other states.
- LOAD (1 cycle): LOAD=1, tap=0, in_win=0 -> CLEAR.
- CLEAR (1 cycle): CLEAR_FLAGS=1, err=0 -> SETTLE.
- SETTLE: SETTLE_CYCLES cycles, inputs ignored -> SAMPLE.
- SAMPLE: SAMPLE_CYCLES cycles; err |= EARLY|LATE each cycle -> EVAL.
- EVAL (1 cycle):
  - pass = !err && !OUT_OF_RANGE.
  - pass && !in_win: first=last=tap, in_win=1.
  - pass && in_win: last=tap.
  - Sweep ends on (!pass && in_win), OUT_OF_RANGE, or tap==MAX_TAPS. Otherwise -> STEP.
- STEP (1 cycle): MOVE=1, DIRECTION=1, tap+1 -> CLEAR. Consecutive up-moves are spaced SETTLE_CYCLES+SAMPLE_CYCLES+3 cycles apart.
- Sweep end:
  - No window, or width=last-first+1 < MIN_WINDOW -> FAIL state. TRAIN_FAIL=1, WINDOW_WIDTH=width (0 if none), no down-moves.
  - Otherwise CENTER_TAP=(first+last)>>1 (floor), back=tap-CENTER_TAP -> RETURN.
- RETURN: while back>0, alternate MOVE=1/DIRECTION=0 and a 1-cycle gap; back decrements per pulse. At back=0 -> DONE.
- DONE/FAIL: TRAIN_DONE or TRAIN_FAIL=1 and sticky, BUSY=0, return to IDLE behaviour. Only the first contiguous window is recorded; later passes are not evaluated.
- Arithmetic: all TAP_W bits unsigned, no wrap. The tap counter never exceeds MAX_TAPS. The first+last sum uses TAP_W+1 bits.

Optional Feature:
- Macro DQS_TRAIN_DIAG_EN.
- Defined: adds outputs FAIL_CODE[1:0] and LAST_SWEEP_TAP[TAP_W-1:0], both reset 0 and updated at sweep end.
  - FAIL_CODE: 0=ok, 1=no window, 2=window < MIN_WINDOW, 3=OUT_OF_RANGE seen before any pass.
  - LAST_SWEEP_TAP: tap at sweep end.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Pass taps 10..30, fail elsewhere -> 31 up-moves; CENTER_TAP=20, WINDOW_WIDTH=21; 11 down-moves; TRAIN_DONE=1.
- EARLY held high at all taps -> 255 up-moves, 0 down-moves, TRAIN_FAIL=1, WINDOW_WIDTH=0 (FAIL_CODE=1 if enabled).
- Pass taps 5..6 only -> sweep ends at tap 7, TRAIN_FAIL=1, WINDOW_WIDTH=2 (FAIL_CODE=2).
- Pass from tap 25, OUT_OF_RANGE asserted at tap 40 -> last=39, CENTER_TAP=32, WINDOW_WIDTH=15, 8 down-moves, DONE.
- Pass taps 200..255 -> sweep stops at MAX_TAPS, CENTER_TAP=227, WINDOW_WIDTH=56, 28 down-moves, DONE.
- SYNC_RST pulsed during SAMPLE at tap 12 -> all outputs 0 next cycle, no MOVE afterwards. TRAIN_START re-asserted while BUSY is ignored; after reset, START yields a LOAD pulse and restarts from tap 0.
